// File: rtl/free_list_ckpt.sv
// free_list_ckpt
// N-way physical register free list with branch checkpoints.
// Picks the lowest-index free PRNs for the rename stage, returns
// the old PRNs of committing instructions to the pool, rebuilds the
// pool from the RRAT on a full squash, and restores a snapshot on a
// branch mispredict.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   alloc_req             per-way destination request
//   alloc_prn             per-way granted PRN (0 for non-requesting ways)
//   alloc_ok              every requesting way was granted this cycle
//   free_count, stall     registered free PRN count, count < N_WAY
//   commit_valid/prn      per-way retirement and old PRN to free
//   squash, rrat_*        full flush, rebuilt from the committed map
//   ckpt_take/ckpt_id     snapshot this cycle's next free list
//   ckpt_restore/_id      recover from a snapshot
module free_list_ckpt #(
    parameter int N_WAY      = 3,
    parameter int PRF_SIZE   = 64,
    parameter int PRF_WIDTH  = 6,
    parameter int ARF_SIZE   = 32,
    parameter int NUM_CKPT   = 4,
    parameter int CKPT_WIDTH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_WAY-1:0]              alloc_req,
    output logic [N_WAY*PRF_WIDTH-1:0]    alloc_prn,
    output logic                          alloc_ok,
    output logic [PRF_WIDTH:0]            free_count,
    output logic                          stall,
    input  logic [N_WAY-1:0]              commit_valid,
    input  logic [N_WAY*PRF_WIDTH-1:0]    commit_prn,
    input  logic                          squash,
    input  logic [ARF_SIZE*PRF_WIDTH-1:0] rrat_rename_table_in,
    input  logic                          ckpt_take,
    input  logic [CKPT_WIDTH-1:0]         ckpt_id,
    input  logic                          ckpt_restore,
    input  logic [CKPT_WIDTH-1:0]         ckpt_restore_id
);

    // Architectural registers start mapped to PRNs 0..ARF_SIZE-1.
    localparam logic [PRF_SIZE-1:0] RESET_LIST =
        {{(PRF_SIZE-ARF_SIZE){1'b1}}, {ARF_SIZE{1'b0}}};
    localparam logic [PRF_WIDTH:0] RESET_COUNT = (PRF_WIDTH+1)'(PRF_SIZE - ARF_SIZE);

    logic [PRF_SIZE-1:0] free_list;
    logic [PRF_SIZE-1:0] ckpt [NUM_CKPT];
    logic [PRF_SIZE-1:0] avail;
    logic [PRF_SIZE-1:0] granted;
    logic [PRF_SIZE-1:0] freed;
    logic [PRF_SIZE-1:0] free_next;
    logic [PRF_WIDTH-1:0] pick;
    logic [PRF_WIDTH:0]  req_count;

    function automatic logic [PRF_WIDTH-1:0] lowest_free(input logic [PRF_SIZE-1:0] v);
        logic found;
        lowest_free = '0;
        found       = 1'b0;
        for (int j = 0; j < PRF_SIZE; j++) begin
            if (v[j] && !found) begin
                lowest_free = PRF_WIDTH'(j);
                found       = 1'b1;
            end
        end
    endfunction

    function automatic logic [PRF_WIDTH:0] count_free(input logic [PRF_SIZE-1:0] v);
        count_free = '0;
        for (int j = 0; j < PRF_SIZE; j++) begin
            count_free = count_free + (PRF_WIDTH+1)'(v[j]);
        end
    endfunction

    always_comb begin
        req_count = '0;
        for (int i = 0; i < N_WAY; i++) begin
            req_count = req_count + (PRF_WIDTH+1)'(alloc_req[i]);
        end
    end

    // free_count always equals popcount(free_list), so this compare
    // guarantees enough free bits for every requesting way.
    assign alloc_ok = !reset && !squash && !ckpt_restore && (req_count <= free_count);
    assign stall    = free_count < (PRF_WIDTH+1)'(N_WAY);

    // Each requesting way takes the lowest bit still available after
    // the lower-numbered ways have taken theirs.
    always_comb begin
        avail     = free_list;
        alloc_prn = '0;
        pick      = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (alloc_req[i]) begin
                pick = lowest_free(avail);
                alloc_prn[i*PRF_WIDTH +: PRF_WIDTH] = pick;
                avail[pick] = 1'b0;
            end
        end
        granted = alloc_ok ? (free_list & ~avail) : '0;
    end

    // PRN 0 is never returned to the pool.
    always_comb begin
        freed = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (commit_valid[i] && (commit_prn[i*PRF_WIDTH +: PRF_WIDTH] != '0)) begin
                freed[commit_prn[i*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
            end
        end
    end

    always_comb begin
        free_next = (free_list & ~granted) | freed;
        if (squash) begin
            // The RRAT already includes this cycle's commits.
            free_next = '1;
            for (int a = 0; a < ARF_SIZE; a++) begin
                free_next[rrat_rename_table_in[a*PRF_WIDTH +: PRF_WIDTH]] = 1'b0;
            end
        end else if (ckpt_restore) begin
            // Anything freed since the snapshot stays free; post-branch
            // allocations come back through the snapshot bits.
            free_next = ckpt[ckpt_restore_id] | free_list | freed;
        end
        free_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_list  <= RESET_LIST;
            free_count <= RESET_COUNT;
            for (int s = 0; s < NUM_CKPT; s++) begin
                ckpt[s] <= RESET_LIST;
            end
        end else begin
            free_list  <= free_next;
            free_count <= count_free(free_next);
            // Snapshot is taken after this cycle's grants, so the branch's
            // own destination stays allocated on restore.
            if (ckpt_take && !squash && !ckpt_restore) begin
                ckpt[ckpt_id] <= free_next;
            end
        end
    end

endmodule

// File: tb/tb_free_list_ckpt.sv
// tb_free_list_ckpt
// Directed and randomized bench for free_list_ckpt. A bit-vector model
// of the free pool plus snapshot copies predicts every output; grants
// come from an ascending queue of free PRN numbers.
module tb_free_list_ckpt;

    localparam int NW = 3;
    localparam int PS = 64;
    localparam int PW = 6;
    localparam int AS = 32;
    localparam int NC = 4;
    localparam int CW = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [NW-1:0]       alloc_req;
    logic [NW*PW-1:0]    alloc_prn;
    logic                alloc_ok;
    logic [PW:0]         free_count;
    logic                stall;
    logic [NW-1:0]       commit_valid;
    logic [NW*PW-1:0]    commit_prn;
    logic                squash;
    logic [AS*PW-1:0]    rrat;
    logic                ckpt_take;
    logic [CW-1:0]       ckpt_id;
    logic                ckpt_restore;
    logic [CW-1:0]       ckpt_restore_id;

    free_list_ckpt #(.N_WAY(NW), .PRF_SIZE(PS), .PRF_WIDTH(PW), .ARF_SIZE(AS),
                     .NUM_CKPT(NC), .CKPT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_prn(alloc_prn),
        .alloc_ok(alloc_ok), .free_count(free_count), .stall(stall),
        .commit_valid(commit_valid), .commit_prn(commit_prn), .squash(squash),
        .rrat_rename_table_in(rrat), .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
    );

    always #5 clock = ~clock;

    bit [PS-1:0] m_free;
    bit [PS-1:0] m_ckpt [NC];
    bit          m_known = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic [NW*PW-1:0] last_prn;
    logic             last_ok;
    logic [PW:0]      last_fc;
    logic             last_stall;

    function automatic int popc(input bit [PS-1:0] v);
        int c = 0;
        for (int j = 0; j < PS; j++) c += int'(v[j]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alloc_req    = '0;
        commit_valid = '0;
        commit_prn   = '0;
        squash       = 1'b0;
        ckpt_take    = 1'b0;
        ckpt_id      = '0;
        ckpt_restore = 1'b0;
        ckpt_restore_id = '0;
    endtask

    task automatic set_identity_rrat();
        for (int i = 0; i < AS; i++) rrat[i*PW +: PW] = PW'(i);
    endtask

    // One clock: compare outputs against the model, then advance the model.
    task automatic step();
        int q[$];
        int k;
        bit exp_ok;
        logic [NW*PW-1:0] exp_prn;
        bit [PS-1:0] granted;
        bit [PS-1:0] freed;
        bit [PS-1:0] nxt;
        #3;
        last_prn = alloc_prn; last_ok = alloc_ok; last_fc = free_count; last_stall = stall;
        k = $countones(alloc_req);
        exp_ok = !reset && !squash && !ckpt_restore && (k <= popc(m_free));
        if (m_known) begin
            chk("free_count", 64'(free_count), 64'(popc(m_free)));
            chk("stall", 64'(stall), 64'(popc(m_free) < NW));
        end
        chk("alloc_ok", 64'(alloc_ok), 64'(exp_ok));
        granted = '0;
        exp_prn = '0;
        if (exp_ok) begin
            for (int j = 0; j < PS; j++) if (m_free[j]) q.push_back(j);
            for (int w = 0; w < NW; w++) begin
                if (alloc_req[w]) begin
                    int p;
                    p = q.pop_front();
                    exp_prn[w*PW +: PW] = PW'(p);
                    granted[p] = 1'b1;
                end
            end
            chk("alloc_prn", 64'(alloc_prn), 64'(exp_prn));
        end
        freed = '0;
        for (int w = 0; w < NW; w++) begin
            int p;
            p = int'(commit_prn[w*PW +: PW]);
            if (commit_valid[w] && p != 0) begin
                if (m_known && !reset && !squash && m_free[p])
                    $display("FAIL commit_of_free_prn: prn %0d already free", p);
                freed[p] = 1'b1;
            end
        end
        @(posedge clock);
        if (reset) begin
            m_free = {{(PS-AS){1'b1}}, {AS{1'b0}}};
            for (int s = 0; s < NC; s++) m_ckpt[s] = m_free;
            m_known = 1'b1;
        end else if (squash) begin
            nxt = '1;
            for (int a = 0; a < AS; a++) nxt[int'(rrat[a*PW +: PW])] = 1'b0;
            nxt[0] = 1'b0;
            m_free = nxt;
        end else if (ckpt_restore) begin
            m_free = m_ckpt[ckpt_restore_id] | m_free | freed;
            m_free[0] = 1'b0;
        end else begin
            m_free = (m_free & ~granted) | freed;
            if (ckpt_take) m_ckpt[ckpt_id] = m_free;
        end
        #1;
    endtask

    // Random legal commit frees: distinct, currently allocated, non-zero.
    task automatic random_commits();
        bit [PS-1:0] used;
        used = '0;
        commit_valid = '0;
        commit_prn   = '0;
        for (int w = 0; w < NW; w++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int t = 0; t < 16; t++) begin
                    int p;
                    p = $urandom_range(1, PS-1);
                    if (!m_free[p] && !used[p] && !commit_valid[w]) begin
                        used[p] = 1'b1;
                        commit_valid[w] = 1'b1;
                        commit_prn[w*PW +: PW] = PW'(p);
                    end
                end
                if (!commit_valid[w] && $urandom_range(0, 3) == 0)
                    commit_valid[w] = 1'b1;
            end
        end
    endtask

    initial begin
        idle_inputs();
        set_identity_rrat();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state and first full-width grant
        step();
        chk("rst_free_count", 64'(last_fc), 64'd32);
        chk("rst_stall", 64'(last_stall), 64'd0);
        alloc_req = 3'b111;
        step();
        chk("first_prn", 64'(last_prn), 64'({6'd34, 6'd33, 6'd32}));
        chk("first_ok", 64'(last_ok), 64'd1);
        alloc_req = 3'b101;
        step();
        chk("after_first_fc", 64'(last_fc), 64'd29);
        chk("sparse_prn", 64'(last_prn), 64'({6'd36, 6'd0, 6'd35}));

        // Commit of PRN 5 (way 0 frees PRN 0, ignored) alongside a grant
        alloc_req    = 3'b111;
        commit_valid = 3'b011;
        commit_prn   = {6'd0, 6'd5, 6'd0};
        step();
        chk("sparse_fc", 64'(last_fc), 64'd27);
        chk("commit_cycle_prn", 64'(last_prn), 64'({6'd39, 6'd38, 6'd37}));
        idle_inputs();
        alloc_req = 3'b001;
        step();
        chk("commit_fc", 64'(last_fc), 64'd25);
        chk("reuse_prn5", 64'(last_prn), 64'({6'd0, 6'd0, 6'd5}));

        // Checkpoint, six post-branch grants, free PRN 7, restore
        idle_inputs();
        ckpt_take = 1'b1;
        ckpt_id   = 2'd1;
        step();
        chk("ckpt_fc", 64'(last_fc), 64'd24);
        idle_inputs();
        alloc_req = 3'b111;
        step();
        commit_valid = 3'b100;
        commit_prn   = {6'd7, 6'd0, 6'd0};
        step();
        idle_inputs();
        alloc_req       = 3'b111;
        ckpt_restore    = 1'b1;
        ckpt_restore_id = 2'd1;
        step();
        chk("restore_ok", 64'(last_ok), 64'd0);
        idle_inputs();
        alloc_req = 3'b001;
        step();
        chk("restore_fc", 64'(last_fc), 64'd25);
        chk("restore_prn7", 64'(last_prn), 64'({6'd0, 6'd0, 6'd7}));
        alloc_req = 3'b111;
        step();
        chk("post_branch_free", 64'(last_prn), 64'({6'd42, 6'd41, 6'd40}));

        // Exhaustion down to exactly two free PRNs
        for (int it = 0; it < 40 && popc(m_free) >= 5; it++) begin
            alloc_req = 3'b111;
            step();
        end
        if (popc(m_free) == 4) begin alloc_req = 3'b011; step(); end
        if (popc(m_free) == 3) begin alloc_req = 3'b001; step(); end
        alloc_req = 3'b111;
        step();
        chk("exhaust_ok", 64'(last_ok), 64'd0);
        chk("exhaust_stall", 64'(last_stall), 64'd1);
        chk("exhaust_fc", 64'(last_fc), 64'd2);
        alloc_req = 3'b011;
        step();
        chk("exhaust_fc_hold", 64'(last_fc), 64'd2);
        chk("exhaust_pair_ok", 64'(last_ok), 64'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            alloc_req = NW'($urandom_range(0, 7));
            random_commits();
            ckpt_take       = ($urandom_range(0, 5) == 0);
            ckpt_id         = CW'($urandom_range(0, NC-1));
            ckpt_restore    = ($urandom_range(0, 15) == 0);
            ckpt_restore_id = CW'($urandom_range(0, NC-1));
            squash          = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 0) set_identity_rrat();
            else for (int a = 0; a < AS; a++) rrat[a*PW +: PW] = PW'($urandom_range(0, PS-1));
            reset = ($urandom_range(0, 499) == 0);
            step();
            reset = 1'b0;
        end

        // Squash with identity RRAT; commits and checkpoint ignored
        idle_inputs();
        set_identity_rrat();
        random_commits();
        alloc_req = 3'b111;
        squash    = 1'b1;
        ckpt_take = 1'b1;
        ckpt_id   = 2'd2;
        step();
        chk("squash_ok", 64'(last_ok), 64'd0);
        idle_inputs();
        alloc_req = 3'b111;
        step();
        chk("squash_fc", 64'(last_fc), 64'd32);
        chk("squash_prn", 64'(last_prn), 64'({6'd34, 6'd33, 6'd32}));
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
